fpmul_pipe: RTL and testbench

FPMUL_PIPE -- requirements
Module: fpmul_pipe

---
 rtl/fp16_pkg.sv | 15 +
 rtl/fp16_classify.sv | 26 ++
 rtl/fpmul_pipe.sv | 129 ++++++++++++
 tb/tb_fpmul_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants and operand classes, used by the multiplier and adder paths.
package fp16_pkg;

   localparam int          FP16_BIAS    = 15;
   localparam logic [15:0] FP16_NAN     = 16'h7C01;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp16_class_e;

endpackage

// File: rtl/fp16_classify.sv
// Splits an FP16 operand into class, sign, biased exponent and significand with hidden bit.
module fp16_classify
   import fp16_pkg::*;
(
   input  logic [15:0] op_i,
   output fp16_class_e cls_o,
   output logic        sign_o,
   output logic [4:0]  exp_o,
   output logic [10:0] sig_o
);

   always_comb begin
      sign_o = op_i[15];
      exp_o  = op_i[14:10];
      sig_o  = {1'b1, op_i[9:0]};
      // subnormals are flushed: a zero exponent is zero regardless of fraction
      if (op_i[14:10] == 5'd0) begin
         cls_o = ZERO;
      end else if (op_i[14:10] == FP16_EXP_MAX) begin
         cls_o = (op_i[9:0] != 10'd0) ? NAN : INF;
      end else begin
         cls_o = NORM;
      end
   end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage FP16 multiplier (classify / multiply / round) with a global-stall handshake.
module fpmul_pipe
   import fp16_pkg::*;
#(
   parameter int STAGES = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] product,
   output logic        out_valid,
   input  logic        out_ready
);

   fp16_class_e        cls_a, cls_b;
   logic               sgn_a, sgn_b;
   logic [4:0]         exp_a, exp_b;
   logic [10:0]        sig_a, sig_b;

   logic               advance;
   logic [STAGES-1:0]  vld_q;

   logic               sign_d, spec_d;
   logic [15:0]        spec_val_d;
   logic signed [6:0]  exp_d;

   logic               sign1_q, spec1_q;
   logic [15:0]        spec_val1_q;
   logic signed [6:0]  exp1_q;
   logic [10:0]        siga1_q, sigb1_q;

   logic               sign2_q, spec2_q;
   logic [15:0]        spec_val2_q;
   logic signed [6:0]  exp2_q;
   logic [21:0]        prod2_q;

   logic               norm_hi, guard, rnd, sticky, round_up;
   logic [10:0]        sig_pre;
   logic [11:0]        sig_rnd;
   logic [9:0]         frac_fin;
   logic signed [6:0]  exp_fin;
   logic [15:0]        product_d, product_q;

   fp16_classify u_cls_a (.op_i(A), .cls_o(cls_a), .sign_o(sgn_a), .exp_o(exp_a), .sig_o(sig_a));
   fp16_classify u_cls_b (.op_i(B), .cls_o(cls_b), .sign_o(sgn_b), .exp_o(exp_b), .sig_o(sig_b));

   assign out_valid = vld_q[STAGES-1];
   assign advance   = ~out_valid | out_ready;
   assign in_ready  = advance;
   assign product   = product_q;

   always_comb begin
      sign_d     = sgn_a ^ sgn_b;
      spec_d     = 1'b1;
      spec_val_d = 16'h0000;
      exp_d      = {2'b00, exp_a} + {2'b00, exp_b} - 7'(FP16_BIAS);
      if (cls_a == NAN || cls_b == NAN) begin
         spec_val_d = FP16_NAN;
      end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
         spec_val_d = FP16_NAN;
      end else if (cls_a == INF || cls_b == INF) begin
         spec_val_d = {sign_d, FP16_EXP_MAX, 10'h000};
      end else if (cls_a == ZERO || cls_b == ZERO) begin
         spec_val_d = {sign_d, 15'h0000};
      end else begin
         spec_d = 1'b0;
      end
   end

   // product lies in [1,4); bit 21 set means one extra exponent step
   always_comb begin
      norm_hi  = prod2_q[21];
      sig_pre  = norm_hi ? prod2_q[21:11] : prod2_q[20:10];
      guard    = norm_hi ? prod2_q[10]    : prod2_q[9];
      rnd      = norm_hi ? prod2_q[9]     : prod2_q[8];
      sticky   = norm_hi ? (|prod2_q[8:0]) : (|prod2_q[7:0]);
      round_up = guard & (rnd | sticky | sig_pre[0]);
      sig_rnd  = {1'b0, sig_pre} + {11'd0, round_up};
      frac_fin = sig_rnd[11] ? sig_rnd[10:1] : sig_rnd[9:0];
      exp_fin  = exp2_q + 7'(norm_hi) + 7'(sig_rnd[11]);
      if (spec2_q) begin
         product_d = spec_val2_q;
      end else if (exp_fin >= 7'sd31) begin
         product_d = {sign2_q, FP16_EXP_MAX, 10'h000};
      end else if (exp_fin <= 7'sd0) begin
         product_d = {sign2_q, 15'h0000};
      end else begin
         product_d = {sign2_q, exp_fin[4:0], frac_fin};
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vld_q       <= '0;
         sign1_q     <= 1'b0;
         spec1_q     <= 1'b0;
         spec_val1_q <= 16'h0000;
         exp1_q      <= '0;
         siga1_q     <= 11'd0;
         sigb1_q     <= 11'd0;
         sign2_q     <= 1'b0;
         spec2_q     <= 1'b0;
         spec_val2_q <= 16'h0000;
         exp2_q      <= '0;
         prod2_q     <= 22'd0;
         product_q   <= 16'h0000;
      end else if (advance) begin
         vld_q       <= {vld_q[STAGES-2:0], in_valid};
         sign1_q     <= sign_d;
         spec1_q     <= spec_d;
         spec_val1_q <= spec_val_d;
         exp1_q      <= exp_d;
         siga1_q     <= sig_a;
         sigb1_q     <= sig_b;
         sign2_q     <= sign1_q;
         spec2_q     <= spec1_q;
         spec_val2_q <= spec_val1_q;
         exp2_q      <= exp1_q;
         prod2_q     <= 22'(siga1_q) * 22'(sigb1_q);
         if (vld_q[1]) begin
            product_q <= product_d;
         end
      end
   end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: directed vectors, stall, reset and random streams.
module tb_fpmul_pipe;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [15:0] A = 16'h0000;
   logic [15:0] B = 16'h0000;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] product;
   logic        out_valid;
   logic        out_ready = 1'b1;

   fpmul_pipe #(.STAGES(3)) dut (
      .CLK(CLK), .RESET(RESET), .A(A), .B(B),
      .in_valid(in_valid), .in_ready(in_ready),
      .product(product), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 CLK = ~CLK;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_pop = 0;
   bit          lat_on = 1'b0;
   bit          rnd_ready = 1'b0;
   bit          hold_pend = 1'b0;
   logic [15:0] hold_prod = 16'h0000;
   logic [15:0] exp_drv = 16'h0000;
   logic [15:0] exp_q[$];
   int          acc_q[$];
   vec_t        vt[22];

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference: exact integer product, rounded by remainder comparison against half an ulp.
   function automatic logic [15:0] ref_mul(logic [15:0] a, logic [15:0] b);
      int  ea, eb, e, p, sh, q, rem, half;
      logic s;
      bit  na, nb, ia, ib, za, zb;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      s  = a[15] ^ b[15];
      na = (ea == 31) && (a[9:0] != 0);
      nb = (eb == 31) && (b[9:0] != 0);
      ia = (ea == 31) && (a[9:0] == 0);
      ib = (eb == 31) && (b[9:0] == 0);
      za = (ea == 0);
      zb = (eb == 0);
      if (na || nb) return 16'h7C01;
      if ((ia && zb) || (ib && za)) return 16'h7C01;
      if (ia || ib) return {s, 5'h1F, 10'h000};
      if (za || zb) return {s, 15'h0000};
      p  = int'({1'b1, a[9:0]}) * int'({1'b1, b[9:0]});
      sh = (p >= (1 << 21)) ? 11 : 10;
      e  = ea + eb - 15 + (sh - 10);
      q  = p >> sh;
      rem  = p - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      if (e >= 31) return {s, 5'h1F, 10'h000};
      if (e <= 0) return {s, 15'h0000};
      return {s, 5'(e), 10'(q)};
   endfunction

   always @(negedge CLK) begin
      if (!RESET) begin
         if (hold_pend) begin
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_product", product, hold_prod);
         end
         chk("in_ready", 16'(in_ready), 16'(!out_valid || out_ready));
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_drv);
            acc_q.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, required no output", product);
            end else begin
               logic [15:0] e;
               int          ac;
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               chk("product", product, e);
               if (lat_on) chk("latency", 16'(cyc - ac), 16'd3);
               n_pop++;
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_prod = product;
      end
   end

   always @(posedge CLK) begin
      if (rnd_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
      int n;
      A        = a;
      B        = b;
      exp_drv  = e;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge CLK);
         if (in_ready) break;
         n++;
         if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_left", 16'(exp_q.size()), 16'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int n0;
      vt[0]  = '{16'h3C00, 16'h3C00, 16'h3C00};
      vt[1]  = '{16'h4000, 16'h4200, 16'h4600};
      vt[2]  = '{16'hBE00, 16'h4000, 16'hC200};
      vt[3]  = '{16'h3C01, 16'h3C01, 16'h3C02};
      vt[4]  = '{16'h7BFF, 16'h7BFF, 16'h7C00};
      vt[5]  = '{16'h0400, 16'h0400, 16'h0000};
      vt[6]  = '{16'h7C00, 16'h0000, 16'h7C01};
      vt[7]  = '{16'hFC00, 16'h4000, 16'hFC00};
      vt[8]  = '{16'h7E00, 16'h3C00, 16'h7C01};
      vt[9]  = '{16'h8000, 16'h3C00, 16'h8000};
      vt[10] = '{16'h0001, 16'h3C00, 16'h0000};
      vt[11] = '{16'h7C00, 16'hC000, 16'hFC00};
      vt[12] = '{16'hC000, 16'hC000, 16'h4400};
      vt[13] = '{16'h3E00, 16'h3E00, 16'h4080};
      vt[14] = '{16'h0000, 16'hFE00, 16'h7C01};
      vt[15] = '{16'h8400, 16'h0400, 16'h8000};
      vt[16] = '{16'h3C01, 16'h3E00, 16'h3E02};
      vt[17] = '{16'h3C03, 16'h3E00, 16'h3E04};
      vt[18] = '{16'h3DA8, 16'h3DA8, 16'h4000};
      vt[19] = '{16'h7800, 16'h4000, 16'h7C00};
      vt[20] = '{16'h2400, 16'h1C00, 16'h0400};
      vt[21] = '{16'h2400, 16'h1800, 16'h0000};

      #1 RESET = 1'b1;
      #2;
      chk("reset_out_valid", 16'(out_valid), 16'd0);
      chk("reset_product", product, 16'h0000);
      chk("reset_in_ready", 16'(in_ready), 16'd1);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;

      // back-to-back directed vectors, first one on the first edge after reset release
      lat_on = 1'b1;
      for (int i = 0; i < 22; i++) send(vt[i].a, vt[i].b, vt[i].p);
      wait_drain();
      lat_on = 1'b0;

      // downstream stall over cycles 3..8 of a five-pair stream
      n0 = n_pop;
      fork
         begin
            for (int i = 3; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].p);
         end
         begin
            repeat (3) @(posedge CLK);
            #1 out_ready = 1'b0;
            for (int k = 0; k < 6; k++) begin
               @(negedge CLK);
               chk("stall_in_ready", 16'(in_ready), 16'd0);
               chk("stall_out_valid", 16'(out_valid), 16'd1);
               @(posedge CLK);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("stall_count", 16'(n_pop - n0), 16'd5);

      // reset with three operations in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(vt[i].a, vt[i].b, vt[i].p);
      chk("pre_reset_valid", 16'(out_valid), 16'd1);
      #1 RESET = 1'b1;
      #1;
      chk("midreset_out_valid", 16'(out_valid), 16'd0);
      chk("midreset_product", product, 16'h0000);
      chk("midreset_in_ready", 16'(in_ready), 16'd1);
      exp_q.delete();
      acc_q.delete();
      hold_pend = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         chk("post_reset_valid", 16'(out_valid), 16'd0);
      end
      @(posedge CLK);
      #1;

      // random normal operands under random backpressure and input bubbles
      rnd_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [15:0] ra, rb;
         ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
         rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
         if ($urandom_range(0, 4) == 0) begin
            @(posedge CLK);
            #1;
         end
         send(ra, rb, ref_mul(ra, rb));
      end
      rnd_ready = 1'b0;
      @(posedge CLK);
      #2 out_ready = 1'b1;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
